ysyx_24090010_lsu: RTL and testbench
====================================

# ysyx_24090010_lsu

Load/store initiator for the npc core: accepts one memory request at a time from the execute stage and drives the data-memory port (addr / len / wdata / we) toward the DPI-backed RAM responder. It waits for the responder's acknowledgement and sign/zero-extends load data. It returns a single-beat response to writeback. It sits between EXU and the data RAM and is the only master on that port.

## Interface
- TIMEOUT_W, 8: width of the wait-cycle watchdog counter; timeout after 2^TIMEOUT_W−1 WAIT cycles.
- clk  input  1  core clock, all state updates on posedge.
- rst  input  1  asynchronous active-low reset (asserted when 0).
- req_valid  input  1  EXU request valid.
- req_ready  output  1  LSU can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- mem_req  output  1  one-cycle access strobe to RAM.
- mem_addr  output  32  access address (unaligned pass-through).
- mem_len  output  32  access length in bytes: 1, 2 or 4.
- mem_we  output  1  write enable.
- mem_wdata  output  32  store data, right-aligned.
- mem_ack  input  1  responder done; mem_rdata valid when mem_we=0.
- mem_rdata  input  32  load data, right-aligned.
- resp_valid  output  1  response available.
- resp_ready  input  1  writeback accepts response.
- resp_rdata  output  32  extended load data (0 for stores).
- resp_err  output  1  access faulted (timeout, or misaligned when enabled).

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On req_valid: latch we/funct3/addr/wdata, go to ISSUE.
- ISSUE: mem_req=1 for exactly this cycle. Outputs: mem_addr/mem_we/mem_wdata from the latch. mem_len = 1 for B/BU, 2 for H/HU, 4 for W. Store funct3 bit 2 is ignored. Next state: mem_ack=1 → DONE, else → WAIT.
- WAIT: mem_req=0, with addr/len/we/wdata held stable. Transitions:
  - mem_ack → DONE.
  - Watchdog reaching all-ones → DONE with resp_err=1.
  - The watchdog clears on entering ISSUE.
- Load data is captured into resp_rdata on the cycle mem_ack=1 (ISSUE or WAIT):
  - B: sign-extend bit 7. H: sign-extend bit 15. BU/HU: zero-extend. W: as-is.
  - Stores return 0.
- DONE: resp_valid=1, with rdata/err stable. On resp_ready → IDLE.
- Reserved funct3 (011, 110, 111) is treated as W.
- mem_ack outside ISSUE/WAIT is ignored.

## Timing
- Reset (rst=0), asynchronous:
  - State goes to IDLE. Outputs: mem_req=0, mem_we=0, resp_valid=0, resp_err=0; mem_addr/mem_len/mem_wdata/resp_rdata=0.
  - req_ready rises to 1 on the first clock after release.
- Reset mid-access abandons the transaction. No response is produced. A store in flight must not be reissued.
- Minimum latency: accept edge → mem_req next cycle → resp_valid the cycle after (ack in ISSUE). Total 3 cycles from req_valid to resp handshake with resp_ready=1.
- Back-to-back throughput: one access per 3 cycles.
- mem_req never stays high more than 1 cycle per transaction.
- mem_we is high only while in ISSUE/WAIT.
- resp_valid holds until resp_ready, regardless of new req_valid; req_ready=0 meanwhile.

## Configuration
- YSYX_24090010_LSU_MISALIGN_TRAP_EN defined:
  - Misalignment means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - A misaligned request goes IDLE → DONE directly, with resp_err=1 and resp_rdata=0.
  - No mem_req is issued.
- Undefined: all addresses pass through unaligned. The responder handles them and the result is never an error.

## Test plan
- LB from 0x80000003, mem_ack in ISSUE, mem_rdata=0x000000F0 → mem_len=1, resp_rdata=0xFFFFFFF0, resp_valid 2 cycles after accept.
- LHU from 0x80000010, mem_ack after 4 WAIT cycles, mem_rdata=0x0000ABCD → resp_rdata=0x0000ABCD, mem_addr/len stable throughout WAIT, mem_req 1 cycle only.
- SW 0xDEADBEEF to 0x80000020 → mem_we=1, mem_len=4, mem_wdata=0xDEADBEEF; resp_rdata=0, resp_err=0. With resp_ready held low 3 cycles, resp_valid stays high and req_ready stays 0.
- mem_ack never asserted, TIMEOUT_W=4 → resp_err=1 after 15 WAIT cycles, then IDLE.
- rst pulled low during WAIT of SB → mem_req/mem_we drop immediately. After release, no response and no second mem_req.
- LW from 0x80000002 → with the macro: resp_err=1, no mem_req. Without it: mem_req issued with mem_len=4, resp_err=0.

Source files
------------

// File: rtl/ysyx_24090010_lsu.sv
// Load/store initiator: one request at a time from EXU to the data-RAM port, single-beat response to writeback.
// Optional misalignment trap: define YSYX_24090010_LSU_MISALIGN_TRAP_EN.
module ysyx_24090010_lsu #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_len,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = TIMEOUT_W'(1);
    // Compare before incrementing, so the last WAIT cycle is the one holding all-ones minus one.
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = ~WDOG_ONE;

    state_t               state;
    logic [2:0]           funct3_q;
    logic [TIMEOUT_W-1:0] wdog;

    // Size comes from funct3[1:0] only, which also folds reserved encodings onto W.
    function automatic logic [31:0] len_of(input logic [1:0] size);
        case (size)
            2'b00:   len_of = 32'd1;
            2'b01:   len_of = 32'd2;
            default: len_of = 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'h0, d[7:0]};
            3'b101:  extend = {16'h0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

`ifdef YSYX_24090010_LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lo[0];
            default: misaligned = (lo != 2'b00);
        endcase
    endfunction
`endif

    // NOTE: every register here is updated with <= so all reads in the same edge see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            funct3_q   <= 3'b000;
            wdog       <= '0;
            req_ready  <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0;
            mem_len    <= 32'h0;
            mem_we     <= 1'b0;
            mem_wdata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        funct3_q  <= req_funct3;
                        mem_addr  <= req_addr;
                        mem_len   <= len_of(req_funct3[1:0]);
                        mem_wdata <= req_wdata;
                        wdog      <= '0;
`ifdef YSYX_24090010_LSU_MISALIGN_TRAP_EN
                        if (misaligned(req_funct3[1:0], req_addr[1:0])) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else
`endif
                        begin
                            state   <= ISSUE;
                            mem_req <= 1'b1;
                            mem_we  <= req_we;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (mem_ack) begin
                        state      <= DONE;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_we ? 32'h0 : extend(funct3_q, mem_rdata);
                    end else if (state == ISSUE) begin
                        state <= WAIT;
                    end else if (wdog == WDOG_LAST) begin
                        state      <= DONE;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        wdog <= wdog + WDOG_ONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24090010_lsu.sv
// Directed self-checking bench for ysyx_24090010_lsu (watchdog width 4 so the timeout is 15 WAIT cycles).
module tb_ysyx_24090010_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_len;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks   = 0;
    int failures = 0;

    ysyx_24090010_lsu #(.TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Called at a negedge in IDLE; returns at the negedge of the ISSUE cycle with req_valid dropped.
    task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready got=%h exp=1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic handshake(input string name);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_handshake got valid=%h ready=%h exp valid=0 ready=1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0;
        req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0; resp_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({req_ready, mem_req, mem_we, resp_valid, resp_err} !== 5'b0 ||
            mem_addr !== 32'h0 || mem_len !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%h req=%h we=%h rv=%h err=%h addr=%h len=%h wd=%h rd=%h exp all 0",
                     req_ready, mem_req, mem_we, resp_valid, resp_err, mem_addr, mem_len, mem_wdata, resp_rdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_before_edge got=%h exp=0", req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after_edge got=%h exp=1", req_ready);
        end
    endtask

    task automatic test_lb;
        accept(1'b0, 3'b000, 32'h8000_0003, 32'h0);
        checks++;
        if (mem_req !== 1'b1 || mem_len !== 32'd1 || mem_addr !== 32'h8000_0003 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL lb_issue got req=%h len=%h addr=%h we=%h rv=%h exp 1/1/80000003/0/0",
                     mem_req, mem_len, mem_addr, mem_we, resp_valid);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_00F0;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FFF0 || resp_err !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL lb_resp got rv=%h rd=%h err=%h req=%h rdy=%h exp 1/fffffff0/0/0/0",
                     resp_valid, resp_rdata, resp_err, mem_req, req_ready);
        end
        handshake("lb");
    endtask

    task automatic test_lhu_wait;
        accept(1'b0, 3'b101, 32'h8000_0010, 32'h0);
        checks++;
        if (mem_req !== 1'b1 || mem_len !== 32'd2) begin
            failures++;
            $display("FAIL lhu_issue got req=%h len=%h exp 1/2", mem_req, mem_len);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || mem_addr !== 32'h8000_0010 || mem_len !== 32'd2 || resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL lhu_wait%0d got req=%h addr=%h len=%h rv=%h exp 0/80000010/2/0",
                         i, mem_req, mem_addr, mem_len, resp_valid);
            end
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_ABCD;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_ABCD || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL lhu_resp got rv=%h rd=%h err=%h exp 1/0000abcd/0", resp_valid, resp_rdata, resp_err);
        end
        handshake("lhu");
    endtask

    task automatic test_sw_stall;
        accept(1'b1, 3'b010, 32'h8000_0020, 32'hDEAD_BEEF);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_len !== 32'd4 || mem_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL sw_issue got req=%h we=%h len=%h wd=%h exp 1/1/4/deadbeef", mem_req, mem_we, mem_len, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b0 ||
                mem_req !== 1'b0 || mem_we !== 1'b0) begin
                failures++;
                $display("FAIL sw_hold%0d got rv=%h rd=%h err=%h rdy=%h req=%h we=%h exp 1/0/0/0/0/0",
                         i, resp_valid, resp_rdata, resp_err, req_ready, mem_req, mem_we);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        handshake("sw");
    endtask

    task automatic test_extend;
        logic [2:0]  f3 [5] = '{3'b100, 3'b001, 3'b011, 3'b000, 3'b110};
        logic [31:0] rd [5] = '{32'hFFFF_FFF0, 32'h0000_7FFF, 32'hCAFE_BABE, 32'h0000_017F, 32'h8000_0001};
        logic [31:0] ex [5] = '{32'h0000_00F0, 32'h0000_7FFF, 32'hCAFE_BABE, 32'h0000_007F, 32'h8000_0001};
        logic [31:0] ln [5] = '{32'd1, 32'd2, 32'd4, 32'd1, 32'd4};
        for (int i = 0; i < 5; i++) begin
            accept(1'b0, f3[i], 32'h8000_0100, 32'h0);
            checks++;
            if (mem_len !== ln[i]) begin
                failures++;
                $display("FAIL ext%0d_len got=%h exp=%h", i, mem_len, ln[i]);
            end
            mem_ack = 1'b1; mem_rdata = rd[i];
            @(negedge clk);
            mem_ack = 1'b0;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== ex[i]) begin
                failures++;
                $display("FAIL ext%0d_rdata got rv=%h rd=%h exp 1/%h", i, resp_valid, resp_rdata, ex[i]);
            end
            handshake("ext");
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] exp_req = 6'b100100;
        logic [5:0] exp_rv  = 6'b010010;
        resp_ready = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0030;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== exp_req[5-i] || resp_valid !== exp_rv[5-i]) begin
                failures++;
                $display("FAIL b2b_cycle%0d got req=%h rv=%h exp %h/%h", i, mem_req, resp_valid, exp_req[5-i], exp_rv[5-i]);
            end
            if (i == 1) begin
                checks++;
                if (resp_rdata !== 32'h1122_3344) begin
                    failures++;
                    $display("FAIL b2b_rdata0 got=%h exp=11223344", resp_rdata);
                end
            end
            if (i == 2) begin
                req_funct3 = 3'b001; req_addr = 32'h8000_0040; mem_rdata = 32'h0000_8001;
            end
            if (i == 4) begin
                req_valid = 1'b0;
                checks++;
                if (resp_rdata !== 32'hFFFF_8001) begin
                    failures++;
                    $display("FAIL b2b_rdata1 got=%h exp=ffff8001", resp_rdata);
                end
            end
        end
        resp_ready = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_timeout;
        accept(1'b0, 3'b010, 32'h8000_0060, 32'h0);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait%0d got rv=%h req=%h exp 0/0", i, resp_valid, mem_req);
            end
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL timeout_resp got rv=%h err=%h we=%h exp 1/1/0", resp_valid, resp_err, mem_we);
        end
        handshake("timeout");
    endtask

    task automatic test_reset_mid_store;
        accept(1'b1, 3'b000, 32'h8000_0050, 32'h0000_00A5);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_len !== 32'd1) begin
            failures++;
            $display("FAIL sb_issue got req=%h we=%h len=%h exp 1/1/1", mem_req, mem_we, mem_len);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL sb_async_reset got req=%h we=%h exp 0/0", mem_req, mem_we);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || resp_valid !== 1'b0 || mem_we !== 1'b0) begin
                failures++;
                $display("FAIL sb_after_reset%0d got req=%h rv=%h we=%h exp 0/0/0", i, mem_req, resp_valid, mem_we);
            end
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL sb_ready_after_reset got=%h exp=1", req_ready);
        end
    endtask

    task automatic test_misalign;
        accept(1'b0, 3'b010, 32'h8000_0002, 32'h0);
`ifdef YSYX_24090010_LSU_MISALIGN_TRAP_EN
        checks++;
        if (mem_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL misalign_trap got req=%h rv=%h err=%h rd=%h exp 0/1/1/0", mem_req, resp_valid, resp_err, resp_rdata);
        end
`else
        checks++;
        if (mem_req !== 1'b1 || mem_len !== 32'd4 || mem_addr !== 32'h8000_0002) begin
            failures++;
            $display("FAIL misalign_issue got req=%h len=%h addr=%h exp 1/4/80000002", mem_req, mem_len, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0000_0055) begin
            failures++;
            $display("FAIL misalign_resp got rv=%h err=%h rd=%h exp 1/0/55", resp_valid, resp_err, resp_rdata);
        end
`endif
        handshake("misalign");
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu_wait();
        test_sw_stall();
        test_extend();
        test_back_to_back();
        test_timeout();
        test_reset_mid_store();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
